// File: rtl/pcie_cont_write_mq.sv
// rtl/pcie_cont_write_mq.sv - host write request fan-out to cores with scratchpad slot and DMA bookkeeping
module pcie_cont_write_mq #(
    parameter int HOST_TAG_WIDTH  = 32,
    parameter int PCIE_ADDR_WIDTH = 64,
    parameter int SLOT_COUNT      = 16,
    parameter int SLOT_ADDR_WIDTH = 11,
    parameter int LEN_WIDTH       = 16,
    parameter int CORE_COUNT      = 16,
    parameter int CORE_ADDR_WIDTH = 16,
    parameter int USER_WIDTH      = 9,
    parameter int HOST_Q_DEPTH    = 4
) (
    input  logic                                        pcie_clk,
    input  logic                                        pcie_rst_n,
    input  logic [PCIE_ADDR_WIDTH-1:0]                  host_desc_pcie_addr,
    input  logic [31:0]                                 host_desc_ram_addr,
    input  logic [LEN_WIDTH-1:0]                        host_desc_len,
    input  logic [HOST_TAG_WIDTH-1:0]                   host_desc_tag,
    input  logic                                        host_desc_valid,
    output logic                                        host_desc_ready,
    output logic [HOST_TAG_WIDTH-1:0]                   host_status_tag,
    output logic                                        host_status_valid,
    output logic [127:0]                                cores_ctrl_m_tdata,
    output logic [$clog2(CORE_COUNT)-1:0]               cores_ctrl_m_tdest,
    output logic                                        cores_ctrl_m_tvalid,
    input  logic                                        cores_ctrl_m_tready,
    output logic [$clog2(SLOT_COUNT)+SLOT_ADDR_WIDTH-1:0] sink_desc_ram_addr,
    output logic [LEN_WIDTH-1:0]                        sink_desc_len,
    output logic [$clog2(SLOT_COUNT)-1:0]               sink_desc_tag,
    output logic                                        sink_desc_valid,
    input  logic                                        sink_desc_ready,
    input  logic [LEN_WIDTH-1:0]                        sink_status_len,
    input  logic [$clog2(SLOT_COUNT)-1:0]               sink_status_tag,
    input  logic [USER_WIDTH-1:0]                       sink_status_user,
    input  logic                                        sink_status_valid,
    input  logic [63:0]                                 hdr_data,
    input  logic                                        hdr_valid,
    output logic [PCIE_ADDR_WIDTH-1:0]                  dma_desc_pcie_addr,
    output logic [$clog2(SLOT_COUNT)+SLOT_ADDR_WIDTH-1:0] dma_desc_ram_addr,
    output logic [LEN_WIDTH-1:0]                        dma_desc_len,
    output logic [$clog2(SLOT_COUNT)-1:0]               dma_desc_tag,
    output logic                                        dma_desc_valid,
    input  logic                                        dma_desc_ready,
    input  logic [$clog2(SLOT_COUNT)-1:0]               dma_status_tag,
    input  logic                                        dma_status_valid,
    output logic [$clog2(SLOT_COUNT):0]                 slots_free,
    output logic                                        err_orphan
);
    localparam int CID_W  = $clog2(CORE_COUNT);
    localparam int SLOT_W = $clog2(SLOT_COUNT);
    localparam int SC_W   = SLOT_W + 1;
    localparam int QP_W   = $clog2(HOST_Q_DEPTH);
    localparam int QC_W   = QP_W + 1;
    localparam int SEQ_W  = USER_WIDTH - CID_W;

    logic [127:0]              ctrl_tdata_q, ctrl_tdata_d;
    logic [CID_W-1:0]          ctrl_tdest_q, ctrl_tdest_d;
    logic                      ctrl_tvalid_q, ctrl_tvalid_d;

    logic [HOST_TAG_WIDTH-1:0] q_mem [CORE_COUNT][HOST_Q_DEPTH];
    logic [QP_W-1:0]           q_wr_q [CORE_COUNT];
    logic [QP_W-1:0]           q_wr_d [CORE_COUNT];
    logic [QP_W-1:0]           q_rd_q [CORE_COUNT];
    logic [QP_W-1:0]           q_rd_d [CORE_COUNT];
    logic [QC_W-1:0]           q_cnt_q [CORE_COUNT];
    logic [QC_W-1:0]           q_cnt_d [CORE_COUNT];

    logic [SLOT_COUNT-1:0]     free_q, free_d;
    logic [SC_W-1:0]           slots_free_q, slots_free_d;
    logic                      hdr_pending_q, hdr_pending_d;
    logic [SLOT_W-1:0]         rec_slot_q, rec_slot_d;
    logic [PCIE_ADDR_WIDTH-1:0] addr_table [SLOT_COUNT];
    logic [USER_WIDTH-1:0]     user_table [SLOT_COUNT];

    logic                      st_valid_q;
    logic [SLOT_W-1:0]         st_tag_q;
    logic [LEN_WIDTH-1:0]      st_len_q;

    logic [PCIE_ADDR_WIDTH-1:0] fifo_addr [SLOT_COUNT];
    logic [LEN_WIDTH-1:0]      fifo_len [SLOT_COUNT];
    logic [SLOT_W-1:0]         fifo_tag [SLOT_COUNT];
    logic [SLOT_W-1:0]         f_wr_q, f_wr_d, f_rd_q, f_rd_d;
    logic [SC_W-1:0]           f_cnt_q, f_cnt_d;

    logic                      host_status_valid_q, host_status_valid_d;
    logic [HOST_TAG_WIDTH-1:0] host_status_tag_q, host_status_tag_d;
    logic                      err_orphan_q, err_orphan_d;

    logic [CID_W-1:0]          host_core;
    logic                      host_fire;
    logic [SLOT_W-1:0]         alloc_slot;
    logic                      sink_fire;
    logic [USER_WIDTH-1:0]     cmp_user;
    logic [CID_W-1:0]          cmp_core;
    logic                      cmp_pop_req, cmp_empty, cmp_pop;
    logic                      f_push, f_pop;
    logic                      unused_ram_hi;

    assign unused_ram_hi = ^host_desc_ram_addr[31:CORE_ADDR_WIDTH+CID_W];

    assign host_core       = host_desc_ram_addr[CORE_ADDR_WIDTH +: CID_W];
    assign host_desc_ready = (!ctrl_tvalid_q || cores_ctrl_m_tready)
                             && (q_cnt_q[host_core] != QC_W'(HOST_Q_DEPTH));
    assign host_fire       = host_desc_valid && host_desc_ready;

    always_comb begin
        alloc_slot = '0;
        for (int i = SLOT_COUNT - 1; i >= 0; i--) begin
            if (free_q[i]) alloc_slot = SLOT_W'(i);
        end
    end

    // Gated by reset so no allocation is offered while the bitmap is being cleared.
    assign sink_desc_valid    = (|free_q) && !hdr_pending_q && pcie_rst_n;
    assign sink_fire          = sink_desc_valid && sink_desc_ready;
    assign sink_desc_ram_addr = {alloc_slot, {SLOT_ADDR_WIDTH{1'b0}}};
    assign sink_desc_len      = LEN_WIDTH'(2 ** SLOT_ADDR_WIDTH);
    assign sink_desc_tag      = alloc_slot;

    assign cmp_user    = user_table[dma_status_tag];
    assign cmp_core    = cmp_user[USER_WIDTH-1 -: CID_W];
    assign cmp_pop_req = dma_status_valid && (cmp_user[SEQ_W-1:0] == '0);
    assign cmp_empty   = (q_cnt_q[cmp_core] == '0);
    assign cmp_pop     = cmp_pop_req && !cmp_empty;

    assign f_push = st_valid_q;
    assign f_pop  = (f_cnt_q != '0) && dma_desc_ready;

    always_comb begin
        ctrl_tdata_d  = ctrl_tdata_q;
        ctrl_tdest_d  = ctrl_tdest_q;
        ctrl_tvalid_d = ctrl_tvalid_q;
        if (host_fire) begin
            ctrl_tdata_d                            = '0;
            ctrl_tdata_d[64 +: PCIE_ADDR_WIDTH]     = host_desc_pcie_addr;
            ctrl_tdata_d[32 +: CORE_ADDR_WIDTH]     = host_desc_ram_addr[CORE_ADDR_WIDTH-1:0];
            ctrl_tdata_d[LEN_WIDTH-1:0]             = host_desc_len;
            ctrl_tdest_d                            = host_core;
            ctrl_tvalid_d                           = 1'b1;
        end else if (cores_ctrl_m_tready) begin
            ctrl_tvalid_d = 1'b0;
        end

        q_wr_d  = q_wr_q;
        q_rd_d  = q_rd_q;
        q_cnt_d = q_cnt_q;
        if (host_fire) q_wr_d[host_core] = q_wr_q[host_core] + 1'b1;
        if (cmp_pop)   q_rd_d[cmp_core]  = q_rd_q[cmp_core] + 1'b1;
        for (int c = 0; c < CORE_COUNT; c++) begin
            case ({host_fire && (host_core == CID_W'(c)), cmp_pop && (cmp_core == CID_W'(c))})
                2'b10:   q_cnt_d[c] = q_cnt_q[c] + 1'b1;
                2'b01:   q_cnt_d[c] = q_cnt_q[c] - 1'b1;
                default: q_cnt_d[c] = q_cnt_q[c];
            endcase
        end

        free_d = free_q;
        if (sink_fire)        free_d[alloc_slot]     = 1'b0;
        if (dma_status_valid) free_d[dma_status_tag] = 1'b1;
        slots_free_d = '0;
        for (int i = 0; i < SLOT_COUNT; i++) begin
            slots_free_d = slots_free_d + SC_W'(free_d[i]);
        end

        hdr_pending_d = hdr_pending_q;
        rec_slot_d    = rec_slot_q;
        if (sink_fire) begin
            hdr_pending_d = 1'b1;
            rec_slot_d    = alloc_slot;
        end else if (hdr_valid && hdr_pending_q) begin
            hdr_pending_d = 1'b0;
        end

        f_wr_d = f_push ? f_wr_q + 1'b1 : f_wr_q;
        f_rd_d = f_pop  ? f_rd_q + 1'b1 : f_rd_q;
        case ({f_push, f_pop})
            2'b10:   f_cnt_d = f_cnt_q + 1'b1;
            2'b01:   f_cnt_d = f_cnt_q - 1'b1;
            default: f_cnt_d = f_cnt_q;
        endcase

        host_status_valid_d = cmp_pop;
        host_status_tag_d   = cmp_pop ? q_mem[cmp_core][q_rd_q[cmp_core]] : host_status_tag_q;
        err_orphan_d        = (hdr_valid && !hdr_pending_q) || (cmp_pop_req && cmp_empty);
    end

    always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
        if (!pcie_rst_n) begin
            ctrl_tdata_q  <= '0;
            ctrl_tdest_q  <= '0;
            ctrl_tvalid_q <= 1'b0;
            for (int c = 0; c < CORE_COUNT; c++) begin
                q_wr_q[c]  <= '0;
                q_rd_q[c]  <= '0;
                q_cnt_q[c] <= '0;
            end
            free_q              <= '1;
            slots_free_q        <= SC_W'(SLOT_COUNT);
            hdr_pending_q       <= 1'b0;
            rec_slot_q          <= '0;
            st_valid_q          <= 1'b0;
            st_tag_q            <= '0;
            st_len_q            <= '0;
            f_wr_q              <= '0;
            f_rd_q              <= '0;
            f_cnt_q             <= '0;
            host_status_valid_q <= 1'b0;
            host_status_tag_q   <= '0;
            err_orphan_q        <= 1'b0;
        end else begin
            ctrl_tdata_q        <= ctrl_tdata_d;
            ctrl_tdest_q        <= ctrl_tdest_d;
            ctrl_tvalid_q       <= ctrl_tvalid_d;
            q_wr_q              <= q_wr_d;
            q_rd_q              <= q_rd_d;
            q_cnt_q             <= q_cnt_d;
            free_q              <= free_d;
            slots_free_q        <= slots_free_d;
            hdr_pending_q       <= hdr_pending_d;
            rec_slot_q          <= rec_slot_d;
            st_valid_q          <= sink_status_valid;
            st_tag_q            <= sink_status_tag;
            st_len_q            <= sink_status_len;
            f_wr_q              <= f_wr_d;
            f_rd_q              <= f_rd_d;
            f_cnt_q             <= f_cnt_d;
            host_status_valid_q <= host_status_valid_d;
            host_status_tag_q   <= host_status_tag_d;
            err_orphan_q        <= err_orphan_d;
        end
    end

    // Storage arrays keep their contents across reset; only pointers/flags are cleared.
    always_ff @(posedge pcie_clk) begin
        if (host_fire) q_mem[host_core][q_wr_q[host_core]] <= host_desc_tag;
        if (hdr_valid && hdr_pending_q) addr_table[rec_slot_q] <= hdr_data[PCIE_ADDR_WIDTH-1:0];
        if (sink_status_valid) user_table[sink_status_tag] <= sink_status_user;
        if (f_push) begin
            fifo_addr[f_wr_q] <= addr_table[st_tag_q];
            fifo_len[f_wr_q]  <= st_len_q;
            fifo_tag[f_wr_q]  <= st_tag_q;
        end
    end

    assign cores_ctrl_m_tdata  = ctrl_tdata_q;
    assign cores_ctrl_m_tdest  = ctrl_tdest_q;
    assign cores_ctrl_m_tvalid = ctrl_tvalid_q;

    assign dma_desc_valid     = (f_cnt_q != '0);
    assign dma_desc_pcie_addr = fifo_addr[f_rd_q];
    assign dma_desc_ram_addr  = {fifo_tag[f_rd_q], {SLOT_ADDR_WIDTH{1'b0}}};
    assign dma_desc_len       = fifo_len[f_rd_q];
    assign dma_desc_tag       = fifo_tag[f_rd_q];

    assign host_status_valid = host_status_valid_q;
    assign host_status_tag   = host_status_tag_q;
    assign slots_free        = slots_free_q;
    assign err_orphan        = err_orphan_q;
endmodule

// File: tb/tb_pcie_cont_write_mq.sv
// tb/tb_pcie_cont_write_mq.sv - directed self-checking bench for pcie_cont_write_mq
module tb_pcie_cont_write_mq;
    logic         pcie_clk = 1'b0;
    logic         pcie_rst_n;
    logic [63:0]  host_desc_pcie_addr;
    logic [31:0]  host_desc_ram_addr;
    logic [15:0]  host_desc_len;
    logic [31:0]  host_desc_tag;
    logic         host_desc_valid;
    logic         host_desc_ready;
    logic [31:0]  host_status_tag;
    logic         host_status_valid;
    logic [127:0] cores_ctrl_m_tdata;
    logic [3:0]   cores_ctrl_m_tdest;
    logic         cores_ctrl_m_tvalid;
    logic         cores_ctrl_m_tready;
    logic [14:0]  sink_desc_ram_addr;
    logic [15:0]  sink_desc_len;
    logic [3:0]   sink_desc_tag;
    logic         sink_desc_valid;
    logic         sink_desc_ready;
    logic [15:0]  sink_status_len;
    logic [3:0]   sink_status_tag;
    logic [8:0]   sink_status_user;
    logic         sink_status_valid;
    logic [63:0]  hdr_data;
    logic         hdr_valid;
    logic [63:0]  dma_desc_pcie_addr;
    logic [14:0]  dma_desc_ram_addr;
    logic [15:0]  dma_desc_len;
    logic [3:0]   dma_desc_tag;
    logic         dma_desc_valid;
    logic         dma_desc_ready;
    logic [3:0]   dma_status_tag;
    logic         dma_status_valid;
    logic [4:0]   slots_free;
    logic         err_orphan;

    int n_checks = 0;
    int n_errors = 0;

    pcie_cont_write_mq dut (
        .pcie_clk(pcie_clk), .pcie_rst_n(pcie_rst_n),
        .host_desc_pcie_addr(host_desc_pcie_addr), .host_desc_ram_addr(host_desc_ram_addr),
        .host_desc_len(host_desc_len), .host_desc_tag(host_desc_tag),
        .host_desc_valid(host_desc_valid), .host_desc_ready(host_desc_ready),
        .host_status_tag(host_status_tag), .host_status_valid(host_status_valid),
        .cores_ctrl_m_tdata(cores_ctrl_m_tdata), .cores_ctrl_m_tdest(cores_ctrl_m_tdest),
        .cores_ctrl_m_tvalid(cores_ctrl_m_tvalid), .cores_ctrl_m_tready(cores_ctrl_m_tready),
        .sink_desc_ram_addr(sink_desc_ram_addr), .sink_desc_len(sink_desc_len),
        .sink_desc_tag(sink_desc_tag), .sink_desc_valid(sink_desc_valid),
        .sink_desc_ready(sink_desc_ready),
        .sink_status_len(sink_status_len), .sink_status_tag(sink_status_tag),
        .sink_status_user(sink_status_user), .sink_status_valid(sink_status_valid),
        .hdr_data(hdr_data), .hdr_valid(hdr_valid),
        .dma_desc_pcie_addr(dma_desc_pcie_addr), .dma_desc_ram_addr(dma_desc_ram_addr),
        .dma_desc_len(dma_desc_len), .dma_desc_tag(dma_desc_tag),
        .dma_desc_valid(dma_desc_valid), .dma_desc_ready(dma_desc_ready),
        .dma_status_tag(dma_status_tag), .dma_status_valid(dma_status_valid),
        .slots_free(slots_free), .err_orphan(err_orphan)
    );

    always #5 pcie_clk = ~pcie_clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge pcie_clk);
    endtask

    task automatic alloc(input logic [63:0] hdr);
        sink_desc_ready = 1'b1;
        cyc();
        sink_desc_ready = 1'b0;
        hdr_valid = 1'b1;
        hdr_data  = hdr;
        cyc();
        hdr_valid = 1'b0;
    endtask

    task automatic status(input logic [3:0] tag, input logic [15:0] len, input logic [8:0] user);
        sink_status_valid = 1'b1;
        sink_status_tag   = tag;
        sink_status_len   = len;
        sink_status_user  = user;
        cyc();
        sink_status_valid = 1'b0;
    endtask

    task automatic complete(input logic [3:0] tag);
        dma_status_valid = 1'b1;
        dma_status_tag   = tag;
        cyc();
        dma_status_valid = 1'b0;
    endtask

    initial begin
        pcie_rst_n = 1'b0;
        host_desc_pcie_addr = '0; host_desc_ram_addr = '0; host_desc_len = '0;
        host_desc_tag = '0; host_desc_valid = 1'b0; cores_ctrl_m_tready = 1'b1;
        sink_desc_ready = 1'b0; sink_status_len = '0; sink_status_tag = '0;
        sink_status_user = '0; sink_status_valid = 1'b0; hdr_data = '0; hdr_valid = 1'b0;
        dma_desc_ready = 1'b0; dma_status_tag = '0; dma_status_valid = 1'b0;
        cyc(); cyc();
        check("rst_outs", 128'({cores_ctrl_m_tvalid, dma_desc_valid, host_status_valid, err_orphan, sink_desc_valid}), 128'(5'b0));
        check("rst_slots_free", 128'(slots_free), 128'(16));
        pcie_rst_n = 1'b1;
        cyc();

        // Single request end to end
        cores_ctrl_m_tready = 1'b0;
        host_desc_valid = 1'b1; host_desc_pcie_addr = 64'h1122334455667788;
        host_desc_ram_addr = 32'h0003_0abc; host_desc_len = 16'd100; host_desc_tag = 32'hA5;
        #1 check("host_ready_idle", 128'(host_desc_ready), 128'(1));
        cyc();
        host_desc_valid = 1'b0;
        check("ctrl_out", {cores_ctrl_m_tvalid, cores_ctrl_m_tdest, cores_ctrl_m_tdata},
              {1'b1, 4'd3, 64'h1122334455667788, 16'h0, 16'h0abc, 16'h0, 16'd100});
        cyc();
        check("ctrl_hold", {cores_ctrl_m_tvalid, cores_ctrl_m_tdata},
              {1'b1, 64'h1122334455667788, 16'h0, 16'h0abc, 16'h0, 16'd100});
        cores_ctrl_m_tready = 1'b1;
        cyc();
        check("ctrl_drop", 128'(cores_ctrl_m_tvalid), 128'(0));
        check("sink_desc0", 128'({sink_desc_valid, sink_desc_ram_addr, sink_desc_len, sink_desc_tag}),
              128'({1'b1, 15'h0, 16'd2048, 4'd0}));
        sink_desc_ready = 1'b1;
        cyc();
        sink_desc_ready = 1'b0;
        #1 check("hdr_pending_blocks", 128'(sink_desc_valid), 128'(0));
        check("slots_free_15", 128'(slots_free), 128'(15));
        hdr_valid = 1'b1; hdr_data = 64'h1000;
        cyc();
        hdr_valid = 1'b0;
        #1 check("sink_desc_next", 128'({sink_desc_valid, sink_desc_tag, err_orphan}), 128'({1'b1, 4'd1, 1'b0}));
        status(4'd0, 16'd100, 9'h060);
        check("dma_not_yet", 128'(dma_desc_valid), 128'(0));
        cyc();
        check("dma_desc1", 128'({dma_desc_valid, dma_desc_pcie_addr, dma_desc_ram_addr, dma_desc_len, dma_desc_tag}),
              128'({1'b1, 64'h1000, 15'h0, 16'd100, 4'd0}));
        dma_desc_ready = 1'b1;
        cyc();
        check("dma_popped", 128'(dma_desc_valid), 128'(0));
        dma_status_valid = 1'b1; dma_status_tag = 4'd0;
        #1 check("host_status_early", 128'(host_status_valid), 128'(0));
        cyc();
        dma_status_valid = 1'b0;
        check("host_status1", 128'({host_status_valid, host_status_tag}), 128'({1'b1, 32'hA5}));
        check("slots_free_16", 128'(slots_free), 128'(16));
        cyc();
        check("host_status_pulse", 128'(host_status_valid), 128'(0));

        // Core queue full
        host_desc_ram_addr = 32'h0005_0000; host_desc_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            host_desc_tag = 32'h50 + 32'(i);
            #1 check("q_push_ready", 128'(host_desc_ready), 128'(1));
            cyc();
        end
        host_desc_tag = 32'h54;
        #1 check("q_full_ready", 128'(host_desc_ready), 128'(0));
        cyc();
        check("q_full_hold", 128'(host_desc_ready), 128'(0));
        alloc(64'h2000);
        status(4'd0, 16'd8, 9'h0A0);
        complete(4'd0);
        check("q_pop_status", 128'({host_status_valid, host_status_tag}), 128'({1'b1, 32'h50}));
        #1 check("q_ready_again", 128'(host_desc_ready), 128'(1));
        cyc();
        host_desc_valid = 1'b0;
        cyc(); cyc();

        // Slot exhaustion and reuse
        for (int i = 0; i < 16; i++) begin
            check("alloc_order", 128'({sink_desc_valid, sink_desc_tag}), 128'({1'b1, 4'(i)}));
            alloc(64'hA000 + 64'(i));
        end
        check("exhausted", 128'({sink_desc_valid, slots_free}), 128'({1'b0, 5'd0}));
        dma_desc_ready = 1'b0;
        status(4'd7, 16'd10, 9'h001);
        cyc();
        check("dma_desc7", 128'({dma_desc_valid, dma_desc_pcie_addr, dma_desc_ram_addr, dma_desc_len, dma_desc_tag}),
              128'({1'b1, 64'hA007, 15'h3800, 16'd10, 4'd7}));
        dma_desc_ready = 1'b1;
        cyc();
        complete(4'd7);
        check("free7", 128'({slots_free, sink_desc_valid, sink_desc_tag, host_status_valid}),
              128'({5'd1, 1'b1, 4'd7, 1'b0}));
        alloc(64'hA007);
        check("realloc7", 128'(slots_free), 128'(0));

        // Same-cycle free and allocate
        status(4'd2, 16'd4, 9'h001);
        complete(4'd7);
        sink_desc_ready = 1'b1; dma_status_valid = 1'b1; dma_status_tag = 4'd2;
        cyc();
        sink_desc_ready = 1'b0; dma_status_valid = 1'b0;
        check("same_cycle", 128'({slots_free, sink_desc_valid, host_status_valid}), 128'({5'd1, 1'b0, 1'b0}));
        hdr_valid = 1'b1; hdr_data = 64'hA007;
        cyc();
        hdr_valid = 1'b0;
        check("same_cycle_next", 128'({sink_desc_valid, sink_desc_tag}), 128'({1'b1, 4'd2}));

        // Orphan completion and orphan header
        alloc(64'hA002);
        status(4'd2, 16'd4, 9'h0C0);
        complete(4'd2);
        check("orphan_cmp", 128'({err_orphan, host_status_valid}), 128'({1'b1, 1'b0}));
        cyc();
        check("orphan_pulse", 128'(err_orphan), 128'(0));
        hdr_valid = 1'b1; hdr_data = 64'hdead;
        cyc();
        hdr_valid = 1'b0;
        check("orphan_hdr", 128'(err_orphan), 128'(1));
        cyc(); cyc(); cyc();
        check("fifo_drained", 128'(dma_desc_valid), 128'(0));

        // Sixteen statuses under backpressure
        dma_desc_ready = 1'b0;
        for (int i = 0; i < 16; i++) status(4'(i), 16'(16 + i), 9'h001);
        cyc();
        dma_desc_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("drain", 128'({dma_desc_valid, dma_desc_pcie_addr, dma_desc_len, dma_desc_tag}),
                  128'({1'b1, 64'hA000 + 64'(i), 16'(16 + i), 4'(i)}));
            cyc();
        end
        check("drain_empty", 128'(dma_desc_valid), 128'(0));

        // Reset in the middle of activity
        dma_desc_ready = 1'b0;
        status(4'd3, 16'd9, 9'h0A0);
        cores_ctrl_m_tready = 1'b0;
        host_desc_valid = 1'b1; host_desc_ram_addr = 32'h0001_0000; host_desc_tag = 32'h77;
        cyc();
        host_desc_valid = 1'b0;
        sink_desc_ready = 1'b1;
        cyc();
        sink_desc_ready = 1'b0;
        complete(4'd3);
        check("pre_rst_status", 128'({host_status_valid, host_status_tag}), 128'({1'b1, 32'h51}));
        check("pre_rst_busy", 128'({dma_desc_valid, cores_ctrl_m_tvalid, sink_desc_valid}), 128'(3'b110));
        #2 pcie_rst_n = 1'b0;
        #1 check("mid_rst_outs", 128'({cores_ctrl_m_tvalid, dma_desc_valid, host_status_valid, err_orphan, sink_desc_valid}), 128'(5'b0));
        check("mid_rst_slots", 128'(slots_free), 128'(16));
        cyc();
        pcie_rst_n = 1'b1; cores_ctrl_m_tready = 1'b1; dma_desc_ready = 1'b1;
        cyc();
        check("post_rst_sink", 128'({sink_desc_valid, sink_desc_tag, slots_free}), 128'({1'b1, 4'd0, 5'd16}));
        complete(4'd3);
        check("post_rst_q_empty", 128'({err_orphan, host_status_valid}), 128'({1'b1, 1'b0}));
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
